// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 4x4 keypad row scanner with frame-based debounce
module keypad_scan_debounce #(
  parameter int ROW_CYCLES = 25000,
  parameter int DEB_FRAMES = 20
) (
  input  logic       ext_clk_25m,
  input  logic       ext_rst_n,
  input  logic [3:0] key_v,
  output logic [3:0] key_h,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       key_valid
);

  localparam int             PW         = $clog2(ROW_CYCLES);
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(ROW_CYCLES - 1);
  localparam logic [7:0]     STABLE_MAX = 8'(DEB_FRAMES - 1);

  typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_t;
  typedef enum logic {RELEASED, PRESSED} deb_t;

  logic [3:0]    r_sync1, r_sync2;
  logic [PW-1:0] r_presc;
  scan_t         r_scan, w_scan_nxt;
  logic [15:0]   r_snap, w_frame;
  logic [4:0]    r_prev, w_res;
  logic [7:0]    r_stable, w_stable_nxt;
  deb_t          r_state, w_state_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic          r_pressed, w_pressed_nxt;
  logic          r_valid, w_valid_nxt;
  logic          w_tick, w_close, w_commit, w_any;
  logic [3:0]    w_idx;

  assign w_tick   = (r_presc == PRESC_MAX);
  assign w_close  = w_tick && (r_scan == SCAN3);
  assign w_commit = w_close && (w_stable_nxt == STABLE_MAX);

  // Scan state advances on prescaler wrap; row drive is one-cold per state.
  always_comb begin
    w_scan_nxt = r_scan;
    key_h      = 4'b1110;
    case (r_scan)
      SCAN0: begin key_h = 4'b1110; if (w_tick) w_scan_nxt = SCAN1; end
      SCAN1: begin key_h = 4'b1101; if (w_tick) w_scan_nxt = SCAN2; end
      SCAN2: begin key_h = 4'b1011; if (w_tick) w_scan_nxt = SCAN3; end
      SCAN3: begin key_h = 4'b0111; if (w_tick) w_scan_nxt = SCAN0; end
      default: w_scan_nxt = SCAN0;
    endcase
  end

  // Snapshot with the current row's live sample merged in, so a frame close sees all 16 keys.
  always_comb begin
    w_frame = r_snap;
    w_frame[{r_scan, 2'b00} +: 4] = ~r_sync2;
    w_any = |w_frame;
    w_idx = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (w_frame[i]) w_idx = 4'(i);
    end
    w_res = w_any ? {1'b1, w_idx} : 5'b0_0000;
  end

  always_comb begin
    w_stable_nxt = 8'h00;
    if (w_res == r_prev) w_stable_nxt = (r_stable == STABLE_MAX) ? r_stable : r_stable + 8'h01;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_pressed_nxt = r_pressed;
    w_valid_nxt   = 1'b0;
    if (w_commit) begin
      case (r_state)
        RELEASED: if (w_res[4]) begin
          w_state_nxt   = PRESSED;
          w_code_nxt    = w_res[3:0];
          w_pressed_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
        end
        PRESSED: if (!w_res[4]) begin
          w_state_nxt   = RELEASED;
          w_pressed_nxt = 1'b0;
        end else if (w_res[3:0] != r_code) begin
          w_code_nxt  = w_res[3:0];
          w_valid_nxt = 1'b1;
        end
        default: w_state_nxt = RELEASED;
      endcase
    end
  end

  always_ff @(posedge ext_clk_25m) begin
    if (!ext_rst_n) begin
      r_sync1   <= 4'hF;
      r_sync2   <= 4'hF;
      r_presc   <= '0;
      r_scan    <= SCAN0;
      r_snap    <= 16'h0000;
      r_prev    <= 5'b0_0000;
      r_stable  <= 8'h00;
      r_state   <= RELEASED;
      r_code    <= 4'h0;
      r_pressed <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_sync1   <= key_v;
      r_sync2   <= r_sync1;
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_scan    <= w_scan_nxt;
      if (w_tick) r_snap <= w_frame;
      if (w_close) begin
        r_stable <= w_stable_nxt;
        r_prev   <= w_res;
      end
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_pressed <= w_pressed_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign key_code    = r_code;
  assign key_pressed = r_pressed;
  assign key_valid   = r_valid;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - scoreboard bench for keypad_scan_debounce
module tb_keypad_scan_debounce;

  typedef struct {
    logic       v;
    logic       p;
    logic [3:0] c;
    int         e;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key_v;
  logic [3:0]  key_h;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        key_valid;
  logic [15:0] keys = 16'h0000;
  int          e = 0;
  int          checks = 0;
  int          passed = 0;
  ev_t         q[$];
  logic [3:0]  exp_h[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan_debounce #(.ROW_CYCLES(4), .DEB_FRAMES(3)) dut (
    .ext_clk_25m(clk),
    .ext_rst_n  (rst_n),
    .key_v      (key_v),
    .key_h      (key_h),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset edge; frame k closes at e == 16*k.
  always @(posedge clk) e <= rst_n ? e + 1 : 0;

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    key_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_h[r] && keys[r*4+c]) key_v[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_e(input int t);
    while (e < t) @(negedge clk);
  endtask

  task automatic do_reset();
    chk("drain", q.size(), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    keys  = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_key_h", key_h, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_pressed", key_pressed, 1'b0);
    chk("rst_valid", key_valid, 1'b0);
  endtask

  // Monitor: any valid pulse or change in the committed state is an output event.
  initial begin
    logic       last_p;
    logic [3:0] last_c;
    ev_t        x;
    last_p = 1'b0;
    last_c = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_p = key_pressed;
        last_c = key_code;
      end else if (key_valid || key_pressed != last_p || key_code != last_c) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: got v=%0b p=%0b c=%0d at e=%0d expected no event",
                   key_valid, key_pressed, key_code, e);
        end else begin
          x = q.pop_front();
          chk("event_value", {key_valid, key_pressed, key_code}, {x.v, x.p, x.c});
          chk("event_time", e, x.e);
        end
        last_p = key_pressed;
        last_c = key_code;
      end
    end
  end

  initial begin
    do_reset();
    for (int i = 0; i < 32; i++) begin
      chk("key_h_seq", key_h, exp_h[(e / 4) % 4]);
      chk("key_h_onecold", $countones(~key_h), 1);
      @(negedge clk);
    end

    do_reset();
    keys = 16'h0200;
    q.push_back('{1'b1, 1'b1, 4'd9, 48});
    wait_e(96);
    keys = 16'h0000;
    q.push_back('{1'b0, 1'b0, 4'd9, 144});
    wait_e(160);
    chk("release_code_hold", key_code, 4'd9);
    chk("release_valid", key_valid, 1'b0);

    do_reset();
    for (int k = 0; k < 6; k++) begin
      wait_e(16 * k);
      keys = (k % 2 == 0) ? 16'h0200 : 16'h0000;
    end
    wait_e(96);
    keys = 16'h0200;
    q.push_back('{1'b1, 1'b1, 4'd9, 144});
    wait_e(176);

    do_reset();
    keys = 16'h0208;
    q.push_back('{1'b1, 1'b1, 4'd3, 48});
    wait_e(48);
    keys = 16'h0200;
    q.push_back('{1'b1, 1'b1, 4'd9, 96});
    wait_e(128);
    chk("multi_pressed", key_pressed, 1'b1);

    do_reset();
    keys = 16'h0200;
    wait_e(24);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_key_h", key_h, 4'b1110);
    chk("midrst_code", key_code, 4'h0);
    chk("midrst_pressed", key_pressed, 1'b0);
    chk("midrst_valid", key_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back('{1'b1, 1'b1, 4'd9, 48});
    wait_e(80);

    chk("final_drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 The block SHALL have parameter ROW_CYCLES, default 25000, giving clock cycles per row drive period (1 ms at 25 MHz); legal range is 4 or more.
REQ-002 The block SHALL have parameter DEB_FRAMES, default 20, giving the number of consecutive identical scan frames required to commit a key state; legal range is 2 to 255.
REQ-003 The block SHALL have port ext_clk_25m, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ext_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port key_v, input, 4 bits: matrix column inputs, asynchronous, active-low (pulled up, 0 = pressed).
REQ-006 The block SHALL have port key_h, output, 4 bits: matrix row drive, one-cold (exactly one bit low).
REQ-007 The block SHALL have port key_code, output, 4 bits: debounced key index, computed as row*4 + column.
REQ-008 The block SHALL have port key_pressed, output, 1 bit: debounced level, 1 while a committed key is held.
REQ-009 The block SHALL have port key_valid, output, 1 bit: one-cycle pulse when a new key or a changed key is committed.

Function
REQ-010 key_v SHALL pass through a 2-flop synchronizer before any use.
REQ-011 A prescaler SHALL count 0..ROW_CYCLES-1 and wrap; row index SHALL advance 0->1->2->3->0 on each prescaler wrap.
REQ-012 Row scan states SCAN0..SCAN3 SHALL drive key_h = 4'b1110, 4'b1101, 4'b1011, 4'b0111 respectively.
REQ-013 Columns SHALL be sampled from the synchronizer output only in the cycle where prescaler = ROW_CYCLES-1, storing 4 bits for the current row in a 16-bit frame snapshot.
REQ-014 A frame SHALL close on the edge where prescaler = ROW_CYCLES-1 and row = 3; frame result = (any-pressed flag, lowest pressed index) over all 16 keys including the row-3 sample taken on that edge.
REQ-015 When multiple keys are pressed, the lowest index SHALL win; when none are pressed, the frame result SHALL be "released", with the code field ignored.
REQ-016 A stable counter (8 bits) SHALL, at each frame close, increment saturating at DEB_FRAMES-1 if the frame result equals the previous frame result, else clear to 0; the previous frame result register SHALL then update.
REQ-017 Debounce FSM SHALL have states RELEASED and PRESSED; a commit occurs at a frame close where the stable counter reaches DEB_FRAMES-1 (DEB_FRAMES identical consecutive frames).
REQ-018 On a commit of "pressed, code c" from RELEASED, or from PRESSED with key_code != c: go to PRESSED, key_code <= c, key_pressed <= 1, key_valid <= 1 for exactly one cycle.
REQ-019 On a commit of "released" from PRESSED: go to RELEASED, key_pressed <= 0, key_code holds its last value, and key_valid stays 0.
REQ-020 A commit equal to the current committed state (saturated counter) SHALL produce no output change and no key_valid pulse.
REQ-021 Outputs SHALL be registered; they change on the frame-closing edge and are visible in the following cycle; worst-case press-to-key_valid latency is (DEB_FRAMES+1)*4*ROW_CYCLES+2 cycles.
REQ-022 A key change mid-frame SHALL only affect rows sampled after it; partial-frame mixtures are treated as ordinary (possibly differing) frame results.

Reset
REQ-023 While ext_rst_n = 0 at a clock edge, the block SHALL set: prescaler 0, row 0, key_h 4'b1110, synchronizer flops 4'hF, snapshot all-released, previous result "released", stable counter 0, FSM RELEASED, key_code 4'h0, key_pressed 0, key_valid 0.
REQ-024 Reset asserted mid-scan or mid-debounce SHALL abandon the frame; after release, scanning SHALL restart at SCAN0 with a full debounce required.

Verification (ROW_CYCLES=4, DEB_FRAMES=3, frame = 16 cycles)
REQ-025 Scenario: hold key_v[1]=0 whenever key_h=4'b1011 from reset -> key_code=9, key_pressed=1, single key_valid pulse at the 3rd frame close, with no further pulses while held.
REQ-026 Scenario: key 9 toggles every frame for 6 frames, then is steady -> no commit during toggling; commit occurs exactly 3 steady frames later.
REQ-027 Scenario: keys 9 and 3 held together -> key_code=3; release key 3 while keeping key 9 -> after 3 frames key_code=9 with one key_valid pulse and key_pressed remaining 1.
REQ-028 Scenario: release all keys after commit -> key_pressed=0 at the 3rd released frame close, key_code holds 9, and key_valid=0.
REQ-029 Scenario: ext_rst_n low for 1 cycle during frame 2 of a press -> all outputs at reset values and key_h=4'b1110 next cycle; commit requires 3 full frames after reset.
REQ-030 Scenario: check key_h over 32 cycles -> sequence 1110, 1101, 1011, 0111 with each value held 4 cycles, and exactly one bit low in every cycle.
